// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the core's single memory port.
// Serialises accesses over a req/ack memory handshake; a watchdog turns hung accesses into error completions.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg;
    logic              last_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              m_req_reg;
    logic              m_we_reg;
    logic [ADDR_W-1:0] m_addr_reg;
    logic [DATA_W-1:0] m_wdata_reg;

    logic select;
    logic pick;
    logic ack_hit;
    logic tmo_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        select     = 1'b0;
        ack_hit    = 1'b0;
        tmo_hit    = 1'b0;
        // On a tie the requester that did not go last wins.
        pick       = (r0_req && r1_req) ? ~last_reg : r1_req;
        case (state_reg)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    select     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ack_hit = m_ack;
                tmo_hit = (TIMEOUT != 0) && !m_ack && (cnt_reg == CNT_LAST);
                if (ack_hit || tmo_hit) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            cnt_reg     <= '0;
            m_req_reg   <= 1'b0;
            m_we_reg    <= 1'b0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
        end else if (select) begin
            owner_reg   <= pick;
            last_reg    <= pick;
            cnt_reg     <= '0;
            m_req_reg   <= 1'b1;
            m_we_reg    <= pick ? r1_we    : r0_we;
            m_addr_reg  <= pick ? r1_addr  : r0_addr;
            m_wdata_reg <= pick ? r1_wdata : r0_wdata;
        end else if (state_reg == ST_WAIT) begin
            if (ack_hit || tmo_hit) m_req_reg <= 1'b0;
            else                    cnt_reg   <= cnt_reg + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            logic              done_reg;
            logic              err_reg;
            logic [DATA_W-1:0] rdata_reg;
            logic              is_owner;

            assign is_owner = (owner_reg == 1'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    done_reg <= is_owner && (ack_hit || tmo_hit);
                    err_reg  <= is_owner && tmo_hit;
                    // Writes leave the read-data register untouched.
                    if (is_owner && ack_hit && !m_we_reg) rdata_reg <= m_rdata;
                    else if (is_owner && tmo_hit)         rdata_reg <= '0;
                end
            end
        end
    endgenerate

    assign r0_done  = g_req[0].done_reg;
    assign r0_err   = g_req[0].err_reg;
    assign r0_rdata = g_req[0].rdata_reg;
    assign r1_done  = g_req[1].done_reg;
    assign r1_err   = g_req[1].err_reg;
    assign r1_rdata = g_req[1].rdata_reg;

    assign busy    = (state_reg != ST_IDLE);
    assign r0_gnt  = busy && (state_reg != ST_IDLE) && !owner_reg;
    assign r1_gnt  = busy && owner_reg;
    assign m_req   = m_req_reg;
    assign m_we    = m_we_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected completions are queued at stimulus time
// and matched against the done pulses; a small memory model answers m_req with a set latency.
module tb_mem_port_arbiter;

    localparam int TP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        m_req, m_we, m_ack = 0;
    logic [31:0] m_addr, m_wdata, m_rdata = 0;
    logic        busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TP)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          mem_lat = 0;
    logic [31:0] mem_key = 32'h5A5A_0000;
    logic [31:0] rmodel [2] = '{32'h0, 32'h0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: acks on the (mem_lat+1)-th cycle of m_req, rdata = addr ^ mem_key.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            m_ack   = 1'b0;
            m_rdata = 32'hBAD0_0000;
            if (m_req) begin
                if (wait_cnt == mem_lat) begin
                    m_ack   = 1'b1;
                    m_rdata = m_addr ^ mem_key;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard: every done pulse retires the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check_eq("gnt_exclusive", {63'b0, r0_gnt & r1_gnt}, 64'd0);
            if (r0_done || r1_done) begin
                $display("TXN r%0d done err=%0b rdata=%08h", r1_done, r1_done ? r1_err : r0_err,
                         r1_done ? r1_rdata : r0_rdata);
                check_eq("done_exclusive", {63'b0, r0_done & r1_done}, 64'd0);
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_who", {63'b0, r1_done}, {63'b0, e.who});
                    check_eq("sb_err", {63'b0, e.who ? r1_err : r0_err}, {63'b0, e.err});
                    check_eq("sb_rdata", {32'b0, e.who ? r1_rdata : r0_rdata}, {32'b0, e.rdata});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic drive(input bit who, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (who) begin r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
        else     begin r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
    endtask

    task automatic push_exp(input bit who, input bit we, input logic [31:0] addr, input bit acked);
        exp_t e;
        e.who   = who;
        e.err   = !acked;
        e.rdata = !acked ? 32'h0 : (we ? rmodel[who] : (addr ^ mem_key));
        rmodel[who] = e.rdata;
        sb_q.push_back(e);
    endtask

    task automatic run_one(input bit who, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat);
        int cyc, mreq_n;
        bit acked, got_done;
        acked = (lat < TP);
        push_exp(who, we, addr, acked);
        mem_lat = lat;
        @(negedge clk);
        drive(who, 1'b1, we, addr, wdata);
        cyc = 0; mreq_n = 0; got_done = 0;
        while (!got_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m_req) mreq_n++;
            if (cyc == 1) begin
                check_eq("m_addr", {32'b0, m_addr}, {32'b0, addr});
                check_eq("m_we", {63'b0, m_we}, {63'b0, we});
                if (we) check_eq("m_wdata", {32'b0, m_wdata}, {32'b0, wdata});
                check_eq("owner_gnt", {62'b0, r1_gnt, r0_gnt}, who ? 64'd2 : 64'd1);
            end
            if (who ? r1_done : r0_done) got_done = 1;
        end
        check_eq("done_cycle", 64'(cyc), 64'(acked ? lat + 2 : TP + 1));
        check_eq("mreq_cycles", 64'(mreq_n), 64'(acked ? lat + 1 : TP));
        drive(who, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("busy_after", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int cyc, n_done, starts, prev_start;
        bit prev_mreq, who_exp;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_mreq", {63'b0, m_req}, 64'd0);
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_gnt", {62'b0, r1_gnt, r0_gnt}, 64'd0);
        check_eq("rst_rdata", {r1_rdata, r0_rdata}, 64'd0);
        check_eq("rst_maddr", {32'b0, m_addr}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Both requesting continuously: alternating grants, one every 3 cycles.
        mem_lat = 0;
        push_exp(1'b0, 1'b0, 32'h200, 1'b1);
        push_exp(1'b1, 1'b0, 32'h300, 1'b1);
        push_exp(1'b0, 1'b0, 32'h200, 1'b1);
        push_exp(1'b1, 1'b0, 32'h300, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        cyc = 0; n_done = 0; starts = 0; prev_start = 0; prev_mreq = 0;
        while (n_done < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (m_req && !prev_mreq) begin
                who_exp = starts[0];
                check_eq("rr_owner", {62'b0, r1_gnt, r0_gnt}, who_exp ? 64'd2 : 64'd1);
                check_eq("rr_addr", {32'b0, m_addr}, who_exp ? 64'h300 : 64'h200);
                if (starts > 0) check_eq("rr_spacing", 64'(cyc - prev_start), 64'd3);
                prev_start = cyc;
                starts++;
            end
            prev_mreq = m_req;
            if (r0_done || r1_done) n_done++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("rr_accesses", 64'(starts), 64'd4);
        @(negedge clk);
        check_eq("rr_busy_after", {63'b0, busy}, 64'd0);

        // Single zero-wait read
        mem_key = 32'hDEADBEEF ^ 32'h40;
        run_one(1'b0, 1'b0, 32'h40, 32'h0, 0);
        check_eq("r0_read_data", {32'b0, r0_rdata}, 64'hDEADBEEF);
        mem_key = 32'h5A5A_0000;

        // r1 write with 4 wait cycles: rdata unchanged
        run_one(1'b1, 1'b1, 32'h100, 32'h1234, 4);
        check_eq("r1_write_rdata_held", {32'b0, r1_rdata}, {32'b0, 32'h300 ^ 32'h5A5A_0000});

        // Watchdog timeout then a normal access
        run_one(1'b0, 1'b0, 32'h80, 32'h0, 1000);
        check_eq("timeout_rdata_zero", {32'b0, r0_rdata}, 64'd0);
        run_one(1'b0, 1'b0, 32'h44, 32'h0, 2);

        // Ack in the same cycle the watchdog would fire
        run_one(1'b1, 1'b0, 32'hC0, 32'h0, TP - 1);

        // Reset mid-WAIT, then a tie goes to r0
        mem_lat = 1000;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("pre_reset_mreq", {63'b0, m_req}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_mreq", {63'b0, m_req}, 64'd0);
        check_eq("async_rst_gnt", {62'b0, r1_gnt, r0_gnt}, 64'd0);
        check_eq("async_rst_busy", {63'b0, busy}, 64'd0);
        check_eq("async_rst_rdata", {r1_rdata, r0_rdata}, 64'd0);
        rmodel[0] = 32'h0;
        rmodel[1] = 32'h0;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        mem_lat = 0;
        @(negedge clk);
        push_exp(1'b0, 1'b0, 32'h600, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
        @(negedge clk);
        check_eq("tie_after_reset_gnt", {62'b0, r1_gnt, r0_gnt}, 64'd1);
        check_eq("tie_after_reset_addr", {32'b0, m_addr}, 64'h600);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc = 0;
        while (!r0_done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("tie_done_cycle", 64'(cyc), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the multicycle RISC-V core. Requester 0 is the core's memory interface, used by the IF and MEM_LD/MEM_SD states; requester 1 is a secondary master such as DMA or a debug loader. The block serialises accesses with round-robin fairness and drives a variable-latency memory through a req/ack handshake. A watchdog turns hung accesses into error completions.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum WAIT cycles without m_ack before an error completion; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_req / r1_req  in  1  request level, held until the matching done pulse.
- r0_we / r1_we  in  1  1 = write, 0 = read; stable while req is high.
- r0_addr / r1_addr  in  ADDR_W  access address; stable while req is high.
- r0_wdata / r1_wdata  in  DATA_W  write data; stable while req is high.
- r0_gnt / r1_gnt  out  1  high while that requester owns the port (WAIT and DONE states).
- r0_done / r1_done  out  1  one-cycle completion pulse.
- r0_err / r1_err  out  1  valid with done; 1 = watchdog timeout.
- r0_rdata / r1_rdata  out  DATA_W  registered read data; updated only on that requester's completion, held otherwise.
- m_req  out  1  memory request, held until m_ack or timeout.
- m_we  out  1  registered copy of the selected requester's we.
- m_addr  out  ADDR_W  registered copy of the selected requester's addr.
- m_wdata  out  DATA_W  registered copy of the selected requester's wdata.
- m_ack  in  1  memory completion; valid only while m_req = 1.
- m_rdata  in  DATA_W  read data, valid with m_ack.
- busy  out  1  high when the state is not IDLE.

## Operation
- State machine: IDLE, WAIT, DONE. Encoding is free.
- IDLE:
  - no request: stay in IDLE.
  - one request: select it.
  - both requests: select the requester that is not `last`.
  - on selection: latch we/addr/wdata into the m_* registers, record the owner, go to WAIT.
- `last` is a 1-bit register updated to the owner at each selection. Reset value is 1, so r0 wins the first tie.
- WAIT:
  - m_req = 1 and the owner's gnt = 1.
  - watchdog counter starts at 0 on entry and increments each WAIT cycle without m_ack.
  - m_ack = 1: capture m_rdata into the owner's rdata register if it is a read (writes leave rdata unchanged), clear err, go to DONE.
  - TIMEOUT != 0 and counter == TIMEOUT - 1 with no m_ack: drop m_req, load 0 into the owner's rdata, set err, go to DONE.
  - m_ack and timeout in the same cycle: m_ack wins, err = 0.
- DONE:
  - owner's done = 1 and err is valid for exactly one cycle; gnt stays high.
  - next state is IDLE unconditionally.
  - the request is retired at the done pulse; a req seen in the following IDLE cycle is a new request with new fields.
- A requester that drops req during WAIT does not abort the access: it completes and done still pulses.
- m_ack seen outside WAIT is ignored.
- Non-owner outputs: gnt, done and err stay 0; rdata is held.
- Reset (asserted at any time, including mid-WAIT):
  - immediately: state = IDLE, m_req = 0, all gnt/done/err/busy = 0.
  - m_we/m_addr/m_wdata = 0, both rdata = 0, last = 1, counter = 0.
  - an in-flight memory access is abandoned with no completion.

## Timing
- Request seen in IDLE at cycle 0 → m_req high from cycle 1.
- m_ack at cycle 1 (zero-wait memory) → done at cycle 2 → IDLE at cycle 3. Minimum 3 cycles per access.
- Back-to-back accesses from one requester: one per 3 cycles with a zero-wait memory. With both requesting continuously, grants alternate r0, r1, r0, ...
- Memory with N wait cycles: done at cycle 2 + N.
- Timeout: m_req is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); done with err = 1 at cycle TIMEOUT + 1.
- All outputs are registered except busy and gnt, which may decode state; no combinational path from any input to any output.

## Test plan
- Single r0 read, addr 0x40, m_ack on the first m_req cycle with m_rdata 0xDEADBEEF → r0_done at cycle 2, r0_rdata = 0xDEADBEEF, r0_err = 0, busy low at cycle 3.
- Both requesters hold req continuously with a zero-wait memory → grant order r0, r1, r0, r1; a new access every 3 cycles; m_addr matches the owner's addr each time.
- r1 write, addr 0x100, wdata 0x1234, memory acks after 4 wait cycles → m_req high for 5 cycles, m_we = 1, r1_done at cycle 6, r1_rdata unchanged.
- TIMEOUT = 8, memory never acks → m_req high for 8 cycles, r0_done with r0_err = 1 and r0_rdata = 0 at cycle 9; a following access succeeds normally.
- reset pulsed low mid-WAIT → m_req, gnt and busy drop immediately; after release, a tie grants r0 first.
- m_ack and timeout in the same cycle → err = 0 and rdata = m_rdata.
